// File: rtl/rvvi_pkg.sv
// Shared RVVI link definitions: ACK frame layout, parser states and header byte helpers.
package rvvi_pkg;

  localparam logic [15:0] ETHERTYPE_DFLT = 16'h88B5;

  localparam logic [4:0] ACK_SRC_OFS  = 5'd6;
  localparam logic [4:0] ACK_TYPE_OFS = 5'd12;
  localparam logic [4:0] ACK_DLY_OFS  = 5'd14;
  localparam logic [4:0] ACK_RET_OFS  = 5'd18;
  localparam logic [4:0] ACK_END      = 5'd26;
  localparam logic [4:0] ACK_HDR_LAST = 5'd13;
  localparam logic [4:0] ACK_PAY_LAST = 5'd25;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_PAY  = 2'd1,
    S_PAD  = 2'd2,
    S_DROP = 2'd3
  } ackparsestate_t;

  // Expected header byte at a given frame offset (source MAC slots return 0 and are masked off).
  function automatic logic [7:0] hdr_byte(input logic [47:0] mac, input logic [15:0] etype,
                                          input logic [4:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      5'd0:    b = mac[47:40];
      5'd1:    b = mac[39:32];
      5'd2:    b = mac[31:24];
      5'd3:    b = mac[23:16];
      5'd4:    b = mac[15:8];
      5'd5:    b = mac[7:0];
      5'd12:   b = etype[15:8];
      5'd13:   b = etype[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic hdr_care(input logic [4:0] idx);
    return (idx < ACK_SRC_OFS) || (idx >= ACK_TYPE_OFS);
  endfunction

endpackage

// File: rtl/rvvi_satcounter.sv
// Saturating event counter used for the ACK parser statistics.
module rvvi_satcounter #(
  parameter int CNTWIDTH = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                en,
  output logic [CNTWIDTH-1:0] count
);

  localparam logic [CNTWIDTH-1:0] ONE = {{(CNTWIDTH-1){1'b0}}, 1'b1};

  logic [CNTWIDTH-1:0] count_r;

  // Count enabled events, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_r <= '0;
    end else if (en && (count_r != '1)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/rvvi_ack_parser.sv
// RVVI host ACK frame parser: filters MAC RX frames for this core and emits the
// {InstrPackDelay, Minstret} record as a one-cycle write into the active list.
module rvvi_ack_parser
  import rvvi_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE = ETHERTYPE_DFLT,
  parameter int          ACKWIDTH  = 96,
  parameter int          CNTWIDTH  = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [47:0]         LocalMac,
  input  logic [7:0]          RxTData,
  input  logic                RxTValid,
  input  logic                RxTLast,
  input  logic                RxTUser,
  output logic                RxTReady,
  output logic                AckValid,
  output logic [ACKWIDTH-1:0] AckData,
  output logic [CNTWIDTH-1:0] AckCount,
  output logic [CNTWIDTH-1:0] DropCount
);

  ackparsestate_t state_r, state_s;
  logic [4:0]     byte_cnt_r, byte_cnt_s;
  logic [31:0]    dly_r, dly_s;
  logic [63:0]    ret_r, ret_s;
  logic           beat_s, hdr_bad_s, accept_s, drop_s;

  assign RxTReady  = 1'b1;
  assign beat_s    = RxTValid & RxTReady;
  assign hdr_bad_s = hdr_care(byte_cnt_r) && (RxTData != hdr_byte(LocalMac, ETHERTYPE, byte_cnt_r));

  // Next-state, byte index and payload staging; accept/drop decided on the tlast beat.
  always_comb begin
    state_s    = state_r;
    byte_cnt_s = byte_cnt_r;
    dly_s      = dly_r;
    ret_s      = ret_r;
    accept_s   = 1'b0;
    drop_s     = 1'b0;
    if (beat_s) begin
      if (RxTLast) begin
        byte_cnt_s = 5'd0;
      end else if (byte_cnt_r == ACK_END) begin
        byte_cnt_s = byte_cnt_r;
      end else begin
        byte_cnt_s = byte_cnt_r + 5'd1;
      end
      case (state_r)
        S_HDR: begin
          if (RxTLast) begin
            drop_s  = 1'b1;
            state_s = S_HDR;
          end else if (hdr_bad_s) begin
            state_s = S_DROP;
          end else if (byte_cnt_r == ACK_HDR_LAST) begin
            state_s = S_PAY;
          end else begin
            state_s = S_HDR;
          end
        end
        S_PAY: begin
          if (byte_cnt_r < ACK_RET_OFS) begin
            dly_s = {dly_r[23:0], RxTData};
          end else begin
            ret_s = {ret_r[55:0], RxTData};
          end
          // A record is only complete once byte 25 has landed in the staging registers.
          if (byte_cnt_r == ACK_PAY_LAST) begin
            if (RxTLast) begin
              accept_s = ~RxTUser;
              drop_s   = RxTUser;
              state_s  = S_HDR;
            end else begin
              state_s = S_PAD;
            end
          end else if (RxTLast) begin
            drop_s  = 1'b1;
            state_s = S_HDR;
          end else begin
            state_s = S_PAY;
          end
        end
        S_PAD: begin
          if (RxTLast) begin
            accept_s = ~RxTUser;
            drop_s   = RxTUser;
            state_s  = S_HDR;
          end else begin
            state_s = S_PAD;
          end
        end
        S_DROP: begin
          if (RxTLast) begin
            drop_s  = 1'b1;
            state_s = S_HDR;
          end else begin
            state_s = S_DROP;
          end
        end
        default: begin
          state_s = S_HDR;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Parser state and registered ACK write port.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= S_HDR;
      byte_cnt_r <= 5'd0;
      dly_r      <= 32'd0;
      ret_r      <= 64'd0;
      AckValid   <= 1'b0;
      AckData    <= '0;
    end else begin
      state_r    <= state_s;
      byte_cnt_r <= byte_cnt_s;
      dly_r      <= dly_s;
      ret_r      <= ret_s;
      AckValid   <= accept_s;
      if (accept_s) begin
        AckData <= {dly_s, ret_s};
      end else begin
        AckData <= AckData;
      end
    end
  end

  rvvi_satcounter #(.CNTWIDTH(CNTWIDTH)) u_ack_cnt (
    .clk    (clk),
    .resetn (resetn),
    .en     (accept_s),
    .count  (AckCount)
  );

  rvvi_satcounter #(.CNTWIDTH(CNTWIDTH)) u_drop_cnt (
    .clk    (clk),
    .resetn (resetn),
    .en     (drop_s),
    .count  (DropCount)
  );

endmodule

// File: tb/tb_rvvi_ack_parser.sv
// Self-checking bench for rvvi_ack_parser: randomized frames checked against a frame-level reference model.
module tb_rvvi_ack_parser;

  typedef logic [7:0] bq_t[$];

  localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [47:0] LocalMac = MAC;
  logic [7:0]  RxTData = 8'h00;
  logic        RxTValid = 1'b0;
  logic        RxTLast = 1'b0;
  logic        RxTUser = 1'b0;
  logic        RxTReady;
  logic        AckValid;
  logic [95:0] AckData;
  logic [15:0] AckCount;
  logic [15:0] DropCount;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rvvi_ack_parser dut (
    .clk       (clk),
    .resetn    (resetn),
    .LocalMac  (LocalMac),
    .RxTData   (RxTData),
    .RxTValid  (RxTValid),
    .RxTLast   (RxTLast),
    .RxTUser   (RxTUser),
    .RxTReady  (RxTReady),
    .AckValid  (AckValid),
    .AckData   (AckData),
    .AckCount  (AckCount),
    .DropCount (DropCount)
  );

  // Observation: cycle of every tlast beat, and cycle/data of every AckValid pulse.
  int          cyc = 0;
  int          tl_cyc[$];
  int          obs_cyc[$];
  logic [95:0] obs_data[$];
  int          dbl_pulse = 0;
  bit          prev_av = 1'b0;

  always @(posedge clk) begin
    if (resetn && RxTValid && RxTLast) tl_cyc.push_back(cyc);
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (AckValid === 1'b1) begin
      obs_data.push_back(AckData);
      obs_cyc.push_back(cyc);
      if (prev_av) dbl_pulse = dbl_pulse + 1;
    end
    prev_av = (AckValid === 1'b1);
  end

  // Reference model: whole-frame accept/drop decision and expected record.
  logic [15:0] m_ack = 16'd0;
  logic [15:0] m_drop = 16'd0;
  logic [95:0] exp_data[$];
  int          exp_tl[$];
  int          frame_idx = 0;

  function automatic bq_t make_frame(logic [47:0] dst, logic [15:0] et, logic [31:0] dly,
                                     logic [63:0] ret, int pad);
    bq_t f;
    for (int i = 0; i < 6; i++) f.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(8'($urandom));
    f.push_back(et[15:8]);
    f.push_back(et[7:0]);
    for (int i = 0; i < 4; i++) f.push_back(dly[31-8*i -: 8]);
    for (int i = 0; i < 8; i++) f.push_back(ret[63-8*i -: 8]);
    for (int i = 0; i < pad; i++) f.push_back(8'($urandom));
    return f;
  endfunction

  function automatic bit ref_accept(bq_t f, bit user, logic [47:0] mac, output logic [95:0] d);
    bit ok;
    d  = 96'd0;
    ok = (f.size() >= 26) && !user;
    if (ok) begin
      for (int i = 0; i < 6; i++) if (f[i] != mac[47-8*i -: 8]) ok = 1'b0;
      if ({f[12], f[13]} != 16'h88B5) ok = 1'b0;
      for (int i = 14; i < 26; i++) d = {d[87:0], f[i]};
    end
    return ok;
  endfunction

  task automatic model_frame(bq_t f, bit user);
    logic [95:0] d;
    if (ref_accept(f, user, LocalMac, d)) begin
      if (m_ack != 16'hFFFF) m_ack = m_ack + 16'd1;
      exp_data.push_back(d);
      exp_tl.push_back(frame_idx);
    end else begin
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end
    frame_idx = frame_idx + 1;
  endtask

  // Drive one frame starting at the current negedge; idle gaps never precede byte 0.
  task automatic send_frame(bq_t f, bit user, int gap_pct);
    model_frame(f, user);
    for (int i = 0; i < f.size(); i++) begin
      while (i > 0 && $urandom_range(99) < gap_pct) begin
        RxTValid = 1'b0;
        RxTData  = 8'($urandom);
        RxTLast  = 1'($urandom);
        @(negedge clk);
      end
      RxTValid = 1'b1;
      RxTData  = f[i];
      RxTLast  = (i == f.size() - 1);
      RxTUser  = (i == f.size() - 1) ? user : 1'($urandom);
      @(negedge clk);
    end
    RxTValid = 1'b0;
    RxTLast  = 1'b0;
    RxTUser  = 1'b0;
  endtask

  task automatic idle(int n);
    RxTValid = 1'b0;
    RxTLast  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (AckValid !== 1'b0) begin n_fail++; $display("FAIL reset_ackvalid got %b exp 0", AckValid); end
    n_checks++; if (AckData !== 96'd0) begin n_fail++; $display("FAIL reset_ackdata got %h exp 0", AckData); end
    n_checks++; if (AckCount !== 16'd0) begin n_fail++; $display("FAIL reset_ackcount got %h exp 0", AckCount); end
    n_checks++; if (DropCount !== 16'd0) begin n_fail++; $display("FAIL reset_dropcount got %h exp 0", DropCount); end
    n_checks++; if (RxTReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", RxTReady); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_valid_ack;
    int o0 = obs_data.size();
    int e0 = exp_data.size();
    send_frame(make_frame(MAC, 16'h88B5, 32'h0000_0010, 64'h5, 34), 1'b0, 0);
    idle(4);
    n_checks++; if (obs_data.size() - o0 !== 1) begin n_fail++; $display("FAIL valid_pulses got %0d exp 1", obs_data.size() - o0); end
    if (obs_data.size() > o0 && exp_tl.size() > e0 && tl_cyc.size() > exp_tl[e0]) begin
      n_checks++; if (obs_data[o0] !== 96'h00000010_0000000000000005) begin n_fail++; $display("FAIL valid_data got %h exp %h", obs_data[o0], 96'h00000010_0000000000000005); end
      n_checks++; if (obs_cyc[o0] !== tl_cyc[exp_tl[e0]] + 1) begin n_fail++; $display("FAIL valid_latency got %0d exp %0d", obs_cyc[o0], tl_cyc[exp_tl[e0]] + 1); end
    end
    n_checks++; if (AckData !== 96'h00000010_0000000000000005) begin n_fail++; $display("FAIL valid_hold got %h", AckData); end
    n_checks++; if (AckCount !== 16'd1) begin n_fail++; $display("FAIL valid_ackcount got %h exp 1", AckCount); end
    n_checks++; if (DropCount !== m_drop) begin n_fail++; $display("FAIL valid_dropcount got %h exp %h", DropCount, m_drop); end
  endtask

  task automatic test_drops;
    int o0 = obs_data.size();
    send_frame(make_frame(48'h02_00_00_00_00_02, 16'h88B5, 32'h1, 64'h1, 34), 1'b0, 0);
    send_frame(make_frame(MAC, 16'h0800, 32'h1, 64'h1, 34), 1'b0, 10);
    idle(4);
    n_checks++; if (obs_data.size() !== o0) begin n_fail++; $display("FAIL drop_pulses got %0d exp 0", obs_data.size() - o0); end
    n_checks++; if (DropCount !== m_drop) begin n_fail++; $display("FAIL drop_dropcount got %h exp %h", DropCount, m_drop); end
    n_checks++; if (AckCount !== m_ack) begin n_fail++; $display("FAIL drop_ackcount got %h exp %h", AckCount, m_ack); end
  endtask

  task automatic test_truncated_err;
    int o0 = obs_data.size();
    bq_t full = make_frame(MAC, 16'h88B5, 32'h2, 64'h2, 34);
    bq_t tr;
    for (int i = 0; i <= 20; i++) tr.push_back(full[i]);
    send_frame(tr, 1'b0, 0);
    send_frame(full, 1'b1, 0);
    idle(4);
    n_checks++; if (obs_data.size() !== o0) begin n_fail++; $display("FAIL trunc_pulses got %0d exp 0", obs_data.size() - o0); end
    n_checks++; if (DropCount !== m_drop) begin n_fail++; $display("FAIL trunc_dropcount got %h exp %h", DropCount, m_drop); end
    n_checks++; if (AckCount !== m_ack) begin n_fail++; $display("FAIL trunc_ackcount got %h exp %h", AckCount, m_ack); end
  endtask

  task automatic test_back_to_back;
    int o0 = obs_data.size();
    int e0 = exp_data.size();
    for (int k = 0; k < 3; k++)
      send_frame(make_frame(MAC, 16'h88B5, $urandom, 64'(7 + k), $urandom_range(0, 10)), 1'b0, 30);
    idle(4);
    n_checks++; if (obs_data.size() - o0 !== 3) begin n_fail++; $display("FAIL b2b_pulses got %0d exp 3", obs_data.size() - o0); end
    for (int k = 0; k < 3; k++) begin
      if (obs_data.size() > o0 + k && exp_tl.size() > e0 + k && tl_cyc.size() > exp_tl[e0+k]) begin
        n_checks++; if (obs_data[o0+k][63:0] !== 64'(7 + k)) begin n_fail++; $display("FAIL b2b_minstret got %h exp %h", obs_data[o0+k][63:0], 64'(7 + k)); end
        n_checks++; if (obs_data[o0+k] !== exp_data[e0+k]) begin n_fail++; $display("FAIL b2b_data got %h exp %h", obs_data[o0+k], exp_data[e0+k]); end
        n_checks++; if (obs_cyc[o0+k] !== tl_cyc[exp_tl[e0+k]] + 1) begin n_fail++; $display("FAIL b2b_latency got %0d exp %0d", obs_cyc[o0+k], tl_cyc[exp_tl[e0+k]] + 1); end
      end
    end
    n_checks++; if (AckCount !== m_ack) begin n_fail++; $display("FAIL b2b_ackcount got %h exp %h", AckCount, m_ack); end
    n_checks++; if (dbl_pulse !== 0) begin n_fail++; $display("FAIL b2b_double_pulse got %0d exp 0", dbl_pulse); end
  endtask

  task automatic test_reset_midframe;
    int o0 = obs_data.size();
    int e0 = exp_data.size();
    bq_t f = make_frame(MAC, 16'h88B5, 32'h0000_0010, 64'h5, 34);
    bq_t rest;
    for (int i = 0; i < 16; i++) begin
      RxTValid = 1'b1; RxTData = f[i]; RxTLast = 1'b0;
      @(negedge clk);
    end
    RxTData = f[16];
    resetn  = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_ack  = 16'd0;
    m_drop = 16'd0;
    n_checks++; if (AckValid !== 1'b0) begin n_fail++; $display("FAIL midrst_ackvalid got %b exp 0", AckValid); end
    n_checks++; if (AckCount !== 16'd0) begin n_fail++; $display("FAIL midrst_ackcount got %h exp 0", AckCount); end
    n_checks++; if (DropCount !== 16'd0) begin n_fail++; $display("FAIL midrst_dropcount got %h exp 0", DropCount); end
    for (int i = 17; i < f.size(); i++) rest.push_back(f[i]);
    send_frame(rest, 1'b0, 0);
    idle(4);
    n_checks++; if (obs_data.size() !== o0) begin n_fail++; $display("FAIL midrst_pulses got %0d exp 0", obs_data.size() - o0); end
    n_checks++; if (AckCount !== m_ack) begin n_fail++; $display("FAIL midrst_tail_ackcount got %h exp %h", AckCount, m_ack); end
    n_checks++; if (DropCount !== m_drop) begin n_fail++; $display("FAIL midrst_tail_dropcount got %h exp %h", DropCount, m_drop); end
    send_frame(make_frame(MAC, 16'h88B5, 32'h33, 64'h44, 0), 1'b0, 0);
    idle(4);
    n_checks++; if (obs_data.size() - o0 !== 1) begin n_fail++; $display("FAIL midrst_next_pulses got %0d exp 1", obs_data.size() - o0); end
    if (obs_data.size() > o0 && exp_data.size() > e0) begin
      n_checks++; if (obs_data[o0] !== exp_data[e0]) begin n_fail++; $display("FAIL midrst_next_data got %h exp %h", obs_data[o0], exp_data[e0]); end
    end
    n_checks++; if (AckCount !== m_ack) begin n_fail++; $display("FAIL midrst_next_ackcount got %h exp %h", AckCount, m_ack); end
  endtask

  task automatic test_random;
    int o0 = obs_data.size();
    int e0 = exp_data.size();
    LocalMac = {16'($urandom), 32'($urandom)};
    idle(2);
    for (int n = 0; n < 40; n++) begin
      int  kind = $urandom_range(0, 5);
      bit  user = 1'b0;
      bq_t f = make_frame(LocalMac, 16'h88B5, $urandom, {$urandom, $urandom}, $urandom_range(0, 20));
      bq_t g;
      case (kind)
        2: begin int ix = $urandom_range(0, 5); f[ix] = f[ix] ^ (8'h01 << $urandom_range(0, 7)); end
        3: begin int ix = $urandom_range(12, 13); f[ix] = f[ix] ^ (8'h01 << $urandom_range(0, 7)); end
        5: user = 1'b1;
        default: ;
      endcase
      if (kind == 4) begin
        int len = $urandom_range(1, 25);
        for (int i = 0; i < len; i++) g.push_back(f[i]);
      end else begin
        g = f;
      end
      send_frame(g, user, 20);
      if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
    end
    idle(4);
    n_checks++; if (obs_data.size() - o0 !== exp_data.size() - e0) begin n_fail++; $display("FAIL rand_pulses got %0d exp %0d", obs_data.size() - o0, exp_data.size() - e0); end
    for (int k = 0; k < exp_data.size() - e0; k++) begin
      if (obs_data.size() > o0 + k && tl_cyc.size() > exp_tl[e0+k]) begin
        n_checks++; if (obs_data[o0+k] !== exp_data[e0+k]) begin n_fail++; $display("FAIL rand_data[%0d] got %h exp %h", k, obs_data[o0+k], exp_data[e0+k]); end
        n_checks++; if (obs_cyc[o0+k] !== tl_cyc[exp_tl[e0+k]] + 1) begin n_fail++; $display("FAIL rand_latency[%0d] got %0d exp %0d", k, obs_cyc[o0+k], tl_cyc[exp_tl[e0+k]] + 1); end
      end
    end
    n_checks++; if (AckCount !== m_ack) begin n_fail++; $display("FAIL rand_ackcount got %h exp %h", AckCount, m_ack); end
    n_checks++; if (DropCount !== m_drop) begin n_fail++; $display("FAIL rand_dropcount got %h exp %h", DropCount, m_drop); end
    LocalMac = MAC;
    idle(2);
  endtask

  task automatic test_saturation;
    int o0 = obs_data.size();
    force dut.u_ack_cnt.count_r = 16'hFFFE;
    @(negedge clk);
    release dut.u_ack_cnt.count_r;
    m_ack = 16'hFFFE;
    for (int k = 0; k < 3; k++)
      send_frame(make_frame(MAC, 16'h88B5, 32'h9, 64'(100 + k), 2), 1'b0, 0);
    idle(4);
    n_checks++; if (obs_data.size() - o0 !== 3) begin n_fail++; $display("FAIL sat_pulses got %0d exp 3", obs_data.size() - o0); end
    n_checks++; if (AckCount !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ackcount got %h exp ffff", AckCount); end
    n_checks++; if (AckCount !== m_ack) begin n_fail++; $display("FAIL sat_model got %h exp %h", AckCount, m_ack); end
    n_checks++; if (dbl_pulse !== 0) begin n_fail++; $display("FAIL sat_double_pulse got %0d exp 0", dbl_pulse); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_valid_ack;
    test_drops;
    test_truncated_err;
    test_back_to_back;
    test_reset_midframe;
    test_random;
    test_saturation;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
